// File: rtl/ahb_lite_master_cmd_if.sv
// Command-side and AHB-Lite bus signals of the command-driven AHB master.
// The master modport is the initiator's view; the slave modport is the bus/command-source view.
interface ahb_lite_master_cmd_if #(
    parameter int AWIDTH = 32
);
    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [AWIDTH-1:0] CMD_ADDR;
    logic [2:0]        CMD_SIZE;
    logic [4:0]        CMD_LEN;
    logic [31:0]       WR_DATA;
    logic              WR_POP;
    logic [31:0]       RD_DATA;
    logic              RD_VALID;
    logic              DONE;
    logic              ERR;
    logic [AWIDTH-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic              HMASTLOCK;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_LEN, WR_DATA,
        input  HRDATA, HREADY, HRESP,
        output CMD_READY, WR_POP, RD_DATA, RD_VALID, DONE, ERR,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_SIZE, CMD_LEN, WR_DATA,
        output HRDATA, HREADY, HRESP,
        input  CMD_READY, WR_POP, RD_DATA, RD_VALID, DONE, ERR,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master_cmd.sv
// AHB-Lite master that turns single/INCR-burst read/write commands into pipelined
// address/data-phase traffic, tolerating wait states and the two-cycle ERROR response.
module ahb_lite_master_cmd #(
    parameter int AWIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    ahb_lite_master_cmd_if.master bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_BURST    = 3'd2;
    localparam logic [2:0] S_LASTDATA = 3'd3;
    localparam logic [2:0] S_ERRCAN   = 3'd4;
    localparam logic [2:0] S_FIN      = 3'd5;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    logic [2:0]        state;
    logic [AWIDTH-1:0] haddr_r;
    logic [1:0]        htrans_r;
    logic              hwrite_r;
    logic [2:0]        hsize_r;
    logic [2:0]        hburst_r;
    logic [4:0]        beats_left;
    logic              dph_vld_p1;
    logic              dph_write_p1;
    logic [31:0]       rd_data_r;
    logic              rd_valid_r;
    logic              err_r;

    logic              accept;
    logic              dph_ok;
    logic [2:0]        cmd_size_c;
    logic [4:0]        cmd_len_c;
    logic [AWIDTH-1:0] next_addr;

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > 3'd2) ? 3'd2 : s;
    endfunction

    function automatic logic [4:0] clamp_len(input logic [4:0] l);
        if (l == 5'd0)
            return 5'd1;
        if (l > 5'd16)
            return 5'd16;
        return l;
    endfunction

    function automatic logic [AWIDTH-1:0] align_addr(input logic [AWIDTH-1:0] a, input logic [2:0] s);
        logic [AWIDTH-1:0] r;
        r = a;
        if (s == 3'd1)
            r[0] = 1'b0;
        else if (s == 3'd2)
            r[1:0] = 2'b00;
        return r;
    endfunction

    assign cmd_size_c = clamp_size(bus.CMD_SIZE);
    assign cmd_len_c  = clamp_len(bus.CMD_LEN);
    assign accept     = bus.CMD_VALID && bus.CMD_READY;
    assign next_addr  = haddr_r + (AWIDTH'(1) << hsize_r);
    // dph_vld_p1 marks the data phase belonging to the previously accepted address.
    assign dph_ok     = dph_vld_p1 && bus.HREADY && !bus.HRESP;

    assign bus.CMD_READY = (state == S_IDLE) || (state == S_FIN);
    assign bus.DONE      = (state == S_FIN);
    assign bus.ERR       = err_r;
    assign bus.RD_DATA   = rd_data_r;
    assign bus.RD_VALID  = rd_valid_r;
    assign bus.WR_POP    = dph_ok && dph_write_p1;
    assign bus.HWDATA    = bus.WR_DATA;
    assign bus.HADDR     = haddr_r;
    assign bus.HTRANS    = htrans_r;
    assign bus.HWRITE    = hwrite_r;
    assign bus.HSIZE     = hsize_r;
    assign bus.HBURST    = hburst_r;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state        <= S_IDLE;
            haddr_r      <= '0;
            htrans_r     <= TR_IDLE;
            hwrite_r     <= 1'b0;
            hsize_r      <= 3'd0;
            hburst_r     <= BURST_SINGLE;
            beats_left   <= 5'd0;
            dph_vld_p1   <= 1'b0;
            dph_write_p1 <= 1'b0;
            rd_data_r    <= 32'd0;
            rd_valid_r   <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            if (dph_ok && !dph_write_p1) begin
                rd_data_r  <= bus.HRDATA;
                rd_valid_r <= 1'b1;
            end

            case (state)
                S_IDLE, S_FIN: begin
                    state <= S_IDLE;
                    if (accept) begin
                        haddr_r    <= align_addr(bus.CMD_ADDR, cmd_size_c);
                        hsize_r    <= cmd_size_c;
                        hwrite_r   <= bus.CMD_WRITE;
                        hburst_r   <= (cmd_len_c == 5'd1) ? BURST_SINGLE : BURST_INCR;
                        beats_left <= cmd_len_c - 5'd1;
                        htrans_r   <= TR_NONSEQ;
                        err_r      <= 1'b0;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR, S_BURST: begin
                    if (dph_vld_p1 && bus.HRESP) begin
                        // Drop the pending address; a single-cycle ERROR aborts at once.
                        htrans_r <= TR_IDLE;
                        if (bus.HREADY) begin
                            err_r      <= 1'b1;
                            dph_vld_p1 <= 1'b0;
                            state      <= S_FIN;
                        end else begin
                            state <= S_ERRCAN;
                        end
                    end else if (bus.HREADY) begin
                        dph_vld_p1   <= 1'b1;
                        dph_write_p1 <= hwrite_r;
                        if (beats_left == 5'd0) begin
                            htrans_r <= TR_IDLE;
                            state    <= S_LASTDATA;
                        end else begin
                            haddr_r    <= next_addr;
                            beats_left <= beats_left - 5'd1;
                            // Crossing a 1KB boundary restarts the burst with NONSEQ.
                            htrans_r   <= (next_addr[10] != haddr_r[10]) ? TR_NONSEQ : TR_SEQ;
                            state      <= S_BURST;
                        end
                    end
                end
                S_LASTDATA: begin
                    if (bus.HRESP && !bus.HREADY) begin
                        state <= S_ERRCAN;
                    end else if (bus.HREADY) begin
                        dph_vld_p1 <= 1'b0;
                        if (bus.HRESP)
                            err_r <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_ERRCAN: begin
                    if (bus.HREADY) begin
                        err_r      <= 1'b1;
                        dph_vld_p1 <= 1'b0;
                        state      <= S_FIN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
